// File: rtl/proc_ctrl_mc_pkg.sv
// Shared types for the multi-cycle controller: opcodes, FSM states, flag bit positions
// and opcode classification helpers.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_MOV  = 4'd7,
        OP_CMP  = 4'd8,
        OP_LDI  = 4'd9,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    // Bit positions inside the {N,V,C,Z} flags vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op <= 4'd9) && (op != OP_CMP);
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        return (op <= 4'd6) || (op == OP_CMP);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/proc_ctrl_mc_if.sv
// Instruction handshake bundle. An instruction transfers on a rising clock edge where
// instr_valid and instr_ready are both 1; done pulses for one cycle when it retires.
interface proc_ctrl_mc_if #(
    parameter int NREGS = 8
);
    localparam int INSTR_W = 4 + 3 * $clog2(NREGS);

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               done;

    modport master (output instr, output instr_valid, input instr_ready, input done);
    modport slave  (input instr, input instr_valid, output instr_ready, output done);
endinterface

// File: rtl/proc_ctrl_mc_regfile.sv
// Register file: one synchronous write port, a combinational operand read port and a
// combinational debug read port; synchronous reset clears every register.
module proc_regfile #(
    parameter int  DATA_W = 8,
    parameter int  NREGS  = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = regs_q[raddr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];
endmodule

// File: rtl/proc_ctrl_mc.sv
// Multi-cycle controller: IDLE -> READ_A -> READ_B -> EXEC -> WB, one instruction per
// five cycles, with flags, a retired-instruction counter, HALT and sticky illegal detection.
module proc_ctrl_mc
    import proc_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NREGS   = 8,
    parameter int  PC_W    = 8,
    localparam int REG_AW  = $clog2(NREGS),
    localparam int INSTR_W = 4 + 3 * REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    proc_ctrl_mc_if.slave       bus,
    output logic [PC_W-1:0]     pc,
    output logic [3:0]          flags,
    output logic                halted,
    output logic                illegal,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output state_t              dbg_state
);
    localparam int M = DATA_W - 1;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q, result_q, result_d, rf_rdata;
    logic [3:0]          flags_q, flags_x_q, flags_x_d;
    logic [PC_W-1:0]     pc_q;
    logic                illegal_q;
    logic [3:0]          op;
    logic [REG_AW-1:0]   rd, rs1, rs2, rf_raddr;
    logic                rf_we, ready, done;
    logic [DATA_W:0]     sum, diff;
    logic                alu_c, alu_v;

    assign op  = instr_q[INSTR_W-1 -: 4];
    assign rd  = instr_q[3*REG_AW-1 -: REG_AW];
    assign rs1 = instr_q[2*REG_AW-1 -: REG_AW];
    assign rs2 = instr_q[REG_AW-1:0];

    // The single read port serves rs1 in READ_A and rs2 in READ_B
    assign rf_raddr = (state_q == S_READ_A) ? rs1 : rs2;

    proc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (rd),
        .wdata_i    (result_q),
        .raddr_i    (rf_raddr),
        .rdata_o    (rf_rdata),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) state_d = S_READ_A;
            end
            S_READ_A: state_d = S_READ_B;
            S_READ_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                done    = 1'b1;
                rf_we   = writes_rd(op);
                state_d = (op == OP_HALT) ? S_HALTED : S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum      = {1'b0, op_a_q} + {1'b0, op_b_q};
        diff     = {1'b0, op_a_q} - {1'b0, op_b_q};
        result_d = op_a_q;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD: begin
                result_d = sum[M:0];
                alu_c    = sum[DATA_W];
                alu_v    = (op_a_q[M] == op_b_q[M]) && (result_d[M] != op_a_q[M]);
            end
            OP_SUB, OP_CMP: begin
                result_d = diff[M:0];
                alu_c    = diff[DATA_W];
                alu_v    = (op_a_q[M] != op_b_q[M]) && (result_d[M] != op_a_q[M]);
            end
            OP_AND: result_d = op_a_q & op_b_q;
            OP_OR:  result_d = op_a_q | op_b_q;
            OP_XOR: result_d = op_a_q ^ op_b_q;
            OP_SHL: begin
                result_d = {op_a_q[M-1:0], 1'b0};
                alu_c    = op_a_q[M];
            end
            OP_SHR: begin
                result_d = {1'b0, op_a_q[M:1]};
                alu_c    = op_a_q[0];
            end
            OP_LDI:  result_d = DATA_W'({rs1, rs2});
            default: result_d = op_a_q;
        endcase
        flags_x_d         = 4'b0000;
        flags_x_d[FLAG_Z] = (result_d == '0);
        flags_x_d[FLAG_N] = result_d[M];
        flags_x_d[FLAG_C] = alu_c;
        flags_x_d[FLAG_V] = alu_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            flags_x_q <= '0;
            flags_q   <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.instr_valid) instr_q <= bus.instr;
            if (state_q == S_READ_A) op_a_q <= rf_rdata;
            if (state_q == S_READ_B) op_b_q <= rf_rdata;
            if (state_q == S_EXEC) begin
                result_q  <= result_d;
                flags_x_q <= flags_x_d;
            end
            if (state_q == S_WB) begin
                pc_q <= pc_q + PC_W'(1);
                if (sets_flags(op)) flags_q <= flags_x_q;
                if (is_illegal(op)) illegal_q <= 1'b1;
            end
        end
    end

    assign bus.instr_ready = ready;
    assign bus.done        = done;
    assign pc              = pc_q;
    assign flags           = flags_q;
    assign halted          = (state_q == S_HALTED);
    assign illegal         = illegal_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_proc_ctrl_mc.sv
// Scoreboard bench for proc_ctrl_mc: directed instructions push hand-computed retire
// results; a monitor pops and compares them on every done pulse.
module tb_proc_ctrl_mc;
    import proc_pkg::*;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int PC_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_ctrl_mc_if #(.NREGS(NREGS)) bus ();

    logic [PC_W-1:0]   pc;
    logic [3:0]        flags;
    logic              halted, illegal;
    logic [2:0]        dbg_addr = '0;
    logic [DATA_W-1:0] dbg_data;
    state_t            dbg_state;

    proc_ctrl_mc #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pc        (pc),
        .flags     (flags),
        .halted    (halted),
        .illegal   (illegal),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] done_cyc;
        logic [2:0]  rd;
        logic [7:0]  old_v;
        logic [7:0]  new_v;
        logic [3:0]  flg;
        logic [7:0]  pcv;
        logic        ill;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [12:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    function automatic logic [12:0] ldi(input logic [2:0] rd, input logic [5:0] imm);
        return mk(4'd9, rd, imm[5:3], imm[2:0]);
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] rd, input logic [7:0] old_v,
                                    input logic [7:0] new_v, input logic [3:0] flg,
                                    input logic [7:0] pcv, input logic ill, input logic hlt);
        exp_t e;
        e.done_cyc = '0;
        e.rd = rd; e.old_v = old_v; e.new_v = new_v;
        e.flg = flg; e.pcv = pcv; e.ill = ill; e.hlt = hlt;
        return e;
    endfunction

    // Drive one instruction; on the handshake push its expected retire record
    task automatic issue(input logic [12:0] ins, input exp_t e, input bit push);
        int waited = 0;
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) begin
            chk("issue_ready_timeout", 32'd0, 32'd1);
        end else begin
            e.done_cyc = cyc + 4;
            if (push) exp_q.push_back(e);
            @(posedge clk);
        end
        #1 bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || mon_busy) && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0 || mon_busy) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    endtask

    // Monitor: every done pulse must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_latency", cyc, mon_e.done_cyc);
                    dbg_addr = mon_e.rd;
                    #1;
                    chk("dbg_old_in_wb", 32'(dbg_data), 32'(mon_e.old_v));
                    @(negedge clk);
                    #1;
                    chk("done_one_cycle", 32'(bus.done), 32'd0);
                    chk("reg_after_wb", 32'(dbg_data), 32'(mon_e.new_v));
                    chk("pc", 32'(pc), 32'(mon_e.pcv));
                    chk("flags", 32'(flags), 32'(mon_e.flg));
                    chk("illegal", 32'(illegal), 32'(mon_e.ill));
                    chk("halted", 32'(halted), 32'(mon_e.hlt));
                    chk("ready_after_wb", 32'(bus.instr_ready), 32'(!mon_e.hlt));
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [12:0] s_ins [4];
    exp_t        s_exp [4];

    initial begin
        int idx, cycles, prev_hs, w, done_seen;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset();

        // Basic load and add
        issue(ldi(3'd1, 6'h2C),          mk_exp(3'd1, 8'h00, 8'h2C, 4'h0, 8'd1, 1'b0, 1'b0), 1'b1);
        issue(ldi(3'd2, 6'h05),          mk_exp(3'd2, 8'h00, 8'h05, 4'h0, 8'd2, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd0, 3'd3, 3'd1, 3'd2), mk_exp(3'd3, 8'h00, 8'h31, 4'h0, 8'd3, 1'b0, 1'b0), 1'b1);
        // Subtract with borrow, then compare equal
        issue(ldi(3'd1, 6'h01),          mk_exp(3'd1, 8'h2C, 8'h01, 4'h0, 8'd4, 1'b0, 1'b0), 1'b1);
        issue(ldi(3'd2, 6'h02),          mk_exp(3'd2, 8'h05, 8'h02, 4'h0, 8'd5, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd1, 3'd3, 3'd1, 3'd2), mk_exp(3'd3, 8'h31, 8'hFF, 4'hA, 8'd6, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd8, 3'd3, 3'd1, 3'd1), mk_exp(3'd3, 8'hFF, 8'hFF, 4'h1, 8'd7, 1'b0, 1'b0), 1'b1);
        // Shifts and signed overflow on add
        issue(ldi(3'd1, 6'h3F),          mk_exp(3'd1, 8'h01, 8'h3F, 4'h1, 8'd8, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd5, 3'd1, 3'd1, 3'd0), mk_exp(3'd1, 8'h3F, 8'h7E, 4'h0, 8'd9, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd5, 3'd1, 3'd1, 3'd0), mk_exp(3'd1, 8'h7E, 8'hFC, 4'h8, 8'd10, 1'b0, 1'b0), 1'b1);
        issue(ldi(3'd2, 6'h30),          mk_exp(3'd2, 8'h02, 8'h30, 4'h8, 8'd11, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd0, 3'd2, 3'd2, 3'd2), mk_exp(3'd2, 8'h30, 8'h60, 4'h0, 8'd12, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd0, 3'd2, 3'd2, 3'd2), mk_exp(3'd2, 8'h60, 8'hC0, 4'hC, 8'd13, 1'b0, 1'b0), 1'b1);
        // Logic ops, MOV, carry out, SHR carry
        issue(mk(4'd6, 3'd4, 3'd2, 3'd0), mk_exp(3'd4, 8'h00, 8'h60, 4'h0, 8'd14, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd2, 3'd5, 3'd1, 3'd2), mk_exp(3'd5, 8'h00, 8'hC0, 4'h8, 8'd15, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd3, 3'd6, 3'd1, 3'd3), mk_exp(3'd6, 8'h00, 8'hFF, 4'h8, 8'd16, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd4, 3'd7, 3'd1, 3'd3), mk_exp(3'd7, 8'h00, 8'h03, 4'h0, 8'd17, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd7, 3'd0, 3'd7, 3'd0), mk_exp(3'd0, 8'h00, 8'h03, 4'h0, 8'd18, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd0, 3'd0, 3'd3, 3'd3), mk_exp(3'd0, 8'h03, 8'hFE, 4'hA, 8'd19, 1'b0, 1'b0), 1'b1);
        issue(mk(4'd6, 3'd7, 3'd7, 3'd0), mk_exp(3'd7, 8'h03, 8'h01, 4'h2, 8'd20, 1'b0, 1'b0), 1'b1);
        drain();

        // Valid held high; HALT junk is presented whenever the controller is busy
        s_ins[0] = ldi(3'd1, 6'h11);          s_exp[0] = mk_exp(3'd1, 8'hFC, 8'h11, 4'h2, 8'd21, 1'b0, 1'b0);
        s_ins[1] = ldi(3'd2, 6'h22);          s_exp[1] = mk_exp(3'd2, 8'hC0, 8'h22, 4'h2, 8'd22, 1'b0, 1'b0);
        s_ins[2] = mk(4'd0, 3'd3, 3'd1, 3'd2); s_exp[2] = mk_exp(3'd3, 8'hFF, 8'h33, 4'h0, 8'd23, 1'b0, 1'b0);
        s_ins[3] = mk(4'd1, 3'd4, 3'd1, 3'd2); s_exp[3] = mk_exp(3'd4, 8'h60, 8'hEF, 4'hA, 8'd24, 1'b0, 1'b0);
        idx = 0; cycles = 0; prev_hs = 0;
        bus.instr_valid = 1'b1;
        while (idx < 4 && cycles < 60) begin
            if (bus.instr_ready) begin
                bus.instr = s_ins[idx];
                s_exp[idx].done_cyc = cyc + 4;
                exp_q.push_back(s_exp[idx]);
                if (idx > 0) chk("handshake_spacing", cyc - prev_hs, 32'd5);
                prev_hs = cyc;
                idx++;
            end else begin
                bus.instr = mk(4'd15, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'd0);
            end
            @(negedge clk);
            cycles++;
        end
        chk("stream_all_accepted", idx, 32'd4);
        bus.instr_valid = 1'b0;
        drain();

        // Illegal opcode is sticky and still retires; then HALT
        issue(mk(4'd12, 3'd5, 3'd1, 3'd2), mk_exp(3'd5, 8'hC0, 8'hC0, 4'hA, 8'd25, 1'b1, 1'b0), 1'b1);
        issue(mk(4'd0, 3'd6, 3'd1, 3'd1),  mk_exp(3'd6, 8'hFF, 8'h22, 4'h0, 8'd26, 1'b1, 1'b0), 1'b1);
        issue(mk(4'd15, 3'd0, 3'd0, 3'd0), mk_exp(3'd0, 8'hFE, 8'hFE, 4'h0, 8'd27, 1'b1, 1'b1), 1'b1);
        drain();
        bus.instr       = ldi(3'd1, 6'h15);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halted_ready_low", 32'(bus.instr_ready), 32'd0);
            chk("halted_stays", 32'(halted), 32'd1);
        end
        chk("halted_pc_frozen", 32'(pc), 32'd27);
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset();

        // Reset during EXEC aborts the instruction
        issue(ldi(3'd1, 6'h05), mk_exp(3'd1, 8'h00, 8'h05, 4'h0, 8'd1, 1'b0, 1'b0), 1'b1);
        issue(ldi(3'd2, 6'h07), mk_exp(3'd2, 8'h00, 8'h07, 4'h0, 8'd2, 1'b0, 1'b0), 1'b1);
        drain();
        issue(mk(4'd0, 3'd4, 3'd1, 3'd2), mk_exp(3'd4, 8'h00, 8'h0C, 4'h0, 8'd3, 1'b0, 1'b0), 1'b0);
        w = 0;
        while (dbg_state != S_EXEC && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("reach_exec", 32'(dbg_state), 32'(S_EXEC));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("idle_after_abort", 32'(dbg_state), 32'(S_IDLE));
        chk("pc_after_abort", 32'(pc), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        chk("no_done_after_abort", done_seen, 32'd0);
        issue(mk(4'd7, 3'd4, 3'd4, 3'd0), mk_exp(3'd4, 8'h00, 8'h00, 4'h0, 8'd1, 1'b0, 1'b0), 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
